// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared op and state encodings for the iterative mult/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_CALC = 2'b10,
        S_FIX  = 2'b11
    } mdu_state_t;

    function automatic logic mdu_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic mdu_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_step
//  Description : One iteration of shift-add multiply or restoring divide.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Remainder stays below the divisor, so the MSB of the trial difference is a clean borrow.
    always_comb begin
        w_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        w_shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, operand};
        w_ge      = ~w_diff[WIDTH];
        if (div_mode) begin
            acc_next = {(w_ge ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
            q_bit    = w_ge;
        end else begin
            acc_next = {w_sum, acc[WIDTH-1:1]};
            q_bit    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter_unit
//  Description : Multi-cycle signed/unsigned multiply/divide with HI/LO regs.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t         r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_div;
    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (r_acc),
        .operand  (r_opnd),
        .div_mode (w_is_div),
        .acc_next (w_acc_next),
        .q_bit    (w_q_bit)
    );

    always_comb begin
        w_is_div = mdu_is_div(r_op);
        w_signed = mdu_is_signed(r_op);
        // The most negative value maps onto itself, which is its correct unsigned magnitude.
        w_mag_a  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
        w_mag_b  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_quo    = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_b_zero = (r_opnd == {WIDTH{1'b0}});
        if (!w_is_div) begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else if (w_b_zero) begin
            w_res_hi = r_a;
            w_res_lo = {WIDTH{1'b1}};
        end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_a        <= '0;
            r_b        <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            if (cancel && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (hi_wr) r_hi <= wr_data;
                        if (lo_wr) r_lo <= wr_data;
                        if (start && !cancel) begin
                            r_op       <= op;
                            r_a        <= src_a;
                            r_b        <= src_b;
                            r_div_zero <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                        r_neg_rem <= w_signed & r_a[WIDTH-1];
                        r_cnt     <= '0;
                        if (w_is_div) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                            r_opnd <= w_mag_b;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                            r_opnd <= w_mag_a;
                        end
                        r_state <= S_CALC;
                    end
                    S_CALC: begin
                        r_acc <= w_acc_next | {{(2*WIDTH-1){1'b0}}, w_q_bit};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_CNT_LAST) r_state <= S_FIX;
                    end
                    S_FIX: begin
                        r_hi       <= w_res_hi;
                        r_lo       <= w_res_lo;
                        r_div_zero <= w_is_div & w_b_zero;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_iter_unit
//  Description : Directed vector bench for the iterative mult/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter_unit;
    import mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;
    localparam int NVEC  = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    always #5 clk = ~clk;

    mdu_iter_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; start is sampled on the following rising edge.
    task automatic launch(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        while (!done && n < LAT + 20) begin
            if (busy) busy_n++;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [NVEC];
        int   n;
        int   bn;
        int   seen;

        vecs[0]  = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{MDU_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{MDU_MULT,  32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
        vecs[7]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[11] = '{MDU_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
        vecs[12] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[13] = '{MDU_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

        rst = 1'b1; start = 1'b0; cancel = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_dz", {31'b0, div_zero}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy_start", i), {31'b0, busy}, 32'h1);
            check($sformatf("v%0d_dz_clear", i), {31'b0, div_zero}, 32'h0);
            wait_done(n, bn);
            check($sformatf("v%0d_latency", i), n, LAT);
            check($sformatf("v%0d_busy_cycles", i), bn, LAT);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d_dz", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
            check($sformatf("v%0d_dz_hold", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
        end

        // Back-to-back: second start issued in the done cycle of the first.
        launch(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n, bn);
        check("b2b_first_lo", lo, 32'h00000001);
        launch(MDU_DIVU, 32'h00000007, 32'h00000002);
        check("b2b_busy", {31'b0, busy}, 32'h1);
        wait_done(n, bn);
        check("b2b_latency", n, LAT);
        check("b2b_hi", hi, 32'h00000001);
        check("b2b_lo", lo, 32'h00000003);

        // mthi/mtlo in IDLE, then a cancelled op with ignored writes/starts while busy.
        @(negedge clk);
        hi_wr = 1'b1; wr_data = 32'hAAAAAAAA;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b1; wr_data = 32'h55555555;
        @(negedge clk);
        lo_wr = 1'b0;
        check("mthi", hi, 32'hAAAAAAAA);
        check("mtlo", lo, 32'h55555555);
        launch(MDU_MULT, 32'h00000003, 32'h00000005);
        repeat (4) @(negedge clk);
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h12345678;
        start = 1'b1; op = MDU_DIVU; src_b = 32'h0;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {31'b0, busy}, 32'h0);
        check("cancel_done", {31'b0, done}, 32'h0);
        check("cancel_hi", hi, 32'hAAAAAAAA);
        check("cancel_lo", lo, 32'h55555555);
        check("cancel_dz", {31'b0, div_zero}, 32'h0);
        seen = 0;
        for (int c = 0; c < LAT + 6; c++) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("cancel_no_done", seen, 0);
        check("cancel_hi_after", hi, 32'hAAAAAAAA);

        // Cancel in IDLE blocks start but lets the mtlo land.
        cancel = 1'b1; start = 1'b1; op = MDU_MULT; lo_wr = 1'b1; wr_data = 32'h0F0F0F0F;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0; lo_wr = 1'b0;
        check("idle_cancel_busy", {31'b0, busy}, 32'h0);
        check("idle_cancel_mtlo", lo, 32'h0F0F0F0F);

        // Asynchronous reset mid-CALC after a divide-by-zero left state behind.
        launch(MDU_DIVU, 32'h12345678, 32'h00000000);
        wait_done(n, bn);
        check("pre_rst_dz", {31'b0, div_zero}, 32'h1);
        @(negedge clk);
        launch(MDU_MULT, 32'hFFFFFFFF, 32'h00000002);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'h0);
        check("arst_done", {31'b0, done}, 32'h0);
        check("arst_dz", {31'b0, div_zero}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        hi_wr = 1'b1; wr_data = 32'hDEADBEEF;
        launch(MDU_MULT, 32'h00000003, 32'h00000005);
        hi_wr = 1'b0;
        check("start_mthi_applied", hi, 32'hDEADBEEF);
        wait_done(n, bn);
        check("post_rst_latency", n, LAT);
        check("post_rst_hi", hi, 32'h0);
        check("post_rst_lo", lo, 32'h0000000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
